// File: rtl/adbg_pkg.sv
// Shared definitions for the advanced debug interface: data register sizing and
// the DR-scan driver state type.
package adbg_pkg;

  localparam int DBG_TOP_DATAREG_LEN = 64;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    SHIFT,
    UPDATE,
    RESP,
    GAP
  } adbg_drv_state_t;

endpackage

// File: rtl/adbg_drv_shreg.sv
// Combined TX/RX DR shift register with down-counting bit counter. TX bits leave
// from bit 0; each TDO bit enters at position len-1 so it lands at its index.
module adbg_drv_shreg #(
  parameter int DATAREG_LEN = 64,
  parameter int LEN_W       = 7
) (
  input  logic                   tck_i,
  input  logic                   trstn_i,
  input  logic                   load_en,
  input  logic                   shift_en,
  input  logic [LEN_W-1:0]       len,
  input  logic [DATAREG_LEN-1:0] data,
  input  logic                   tdo_i,
  output logic [DATAREG_LEN-1:0] shreg,
  output logic                   cnt_zero
);

  logic [LEN_W-1:0]       cnt_q;
  logic [LEN_W-1:0]       len_q;
  logic [DATAREG_LEN-1:0] len_mask;
  logic [DATAREG_LEN-1:0] shifted;

  // Masking at load keeps every bit at or above len zero for the whole scan.
  always_comb begin
    len_mask = '0;
    for (int i = 0; i < DATAREG_LEN; i++) begin
      len_mask[i] = (i < int'(len));
    end
  end

  always_comb begin
    shifted = shreg >> 1;
    for (int i = 0; i < DATAREG_LEN; i++) begin
      if (i == int'(len_q) - 1) begin
        shifted[i] = tdo_i;
      end
    end
  end

  always_ff @(posedge tck_i or negedge trstn_i) begin
    if (!trstn_i) begin
      shreg <= '0;
      len_q <= '0;
      cnt_q <= '0;
    end else if (load_en) begin
      shreg <= data & len_mask;
      len_q <= len;
      cnt_q <= len - LEN_W'(1);
    end else if (shift_en) begin
      shreg <= shifted;
      if (cnt_q != '0) begin
        cnt_q <= cnt_q - LEN_W'(1);
      end
    end
  end

  assign cnt_zero = (cnt_q == '0);

endmodule

// File: rtl/adbg_dr_driver.sv
// DR-scan driver: turns request/response transactions into TAP Capture/Shift/
// Update-DR strobe sequences with serial TDI/TDO data.
module adbg_dr_driver
  import adbg_pkg::*;
#(
  parameter int DATAREG_LEN = DBG_TOP_DATAREG_LEN,
  parameter int LEN_W       = 7,
  parameter int IDLE_GAP    = 1
) (
  input  logic                   tck_i,
  input  logic                   trstn_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [LEN_W-1:0]       req_len_i,
  input  logic [DATAREG_LEN-1:0] req_data_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [DATAREG_LEN-1:0] rsp_data_o,
  output logic                   rsp_err_o,
  output logic                   debug_select_o,
  output logic                   capture_dr_o,
  output logic                   shift_dr_o,
  output logic                   update_dr_o,
  output logic                   tdi_o,
  input  logic                   tdo_i
);

  localparam int GAP_W = (IDLE_GAP > 1) ? $clog2(IDLE_GAP + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

  adbg_drv_state_t        state_q;
  adbg_drv_state_t        state_d;
  logic [GAP_W-1:0]       gap_q;
  logic                   err_q;
  logic                   len_legal;
  logic                   accept;
  logic                   cnt_zero;
  logic [DATAREG_LEN-1:0] shreg;

  assign len_legal = (req_len_i != '0) && (int'(req_len_i) <= DATAREG_LEN);
  assign accept    = req_ready_o && req_valid_i;

  adbg_drv_shreg #(
    .DATAREG_LEN(DATAREG_LEN),
    .LEN_W      (LEN_W)
  ) u_shreg (
    .tck_i   (tck_i),
    .trstn_i (trstn_i),
    .load_en (accept && len_legal),
    .shift_en(state_q == SHIFT),
    .len     (req_len_i),
    .data    (req_data_i),
    .tdo_i   (tdo_i),
    .shreg   (shreg),
    .cnt_zero(cnt_zero)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid_i) state_d = len_legal ? CAPTURE : RESP;
      CAPTURE: state_d = SHIFT;
      SHIFT:   if (cnt_zero) state_d = UPDATE;
      UPDATE:  state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = (IDLE_GAP == 0) ? IDLE : GAP;
      GAP:     if (gap_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they come straight out of flops.
  always_ff @(posedge tck_i or negedge trstn_i) begin
    if (!trstn_i) begin
      state_q        <= IDLE;
      gap_q          <= '0;
      err_q          <= 1'b0;
      capture_dr_o   <= 1'b0;
      shift_dr_o     <= 1'b0;
      update_dr_o    <= 1'b0;
      debug_select_o <= 1'b0;
    end else begin
      state_q        <= state_d;
      capture_dr_o   <= (state_d == CAPTURE);
      shift_dr_o     <= (state_d == SHIFT);
      update_dr_o    <= (state_d == UPDATE);
      debug_select_o <= (state_d == CAPTURE) || (state_d == SHIFT) || (state_d == UPDATE);
      if (accept) begin
        err_q <= !len_legal;
      end
      if (state_q == RESP) begin
        gap_q <= GAP_INIT;
      end else if ((state_q == GAP) && (gap_q != '0)) begin
        gap_q <= gap_q - GAP_W'(1);
      end
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_err_o   = rsp_valid_o && err_q;
  assign rsp_data_o  = (rsp_valid_o && !err_q) ? shreg : '0;
  assign tdi_o       = shift_dr_o && shreg[0];

endmodule
